// File: rtl/boot_loader.sv
// Boot loader: copies a program image from the boot ROM into main memory,
// optionally reads it back for comparison, then pulses cpu_start to the Control Unit.
module boot_loader #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    IMAGE_WORDS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WE_CYCLES   = 1,
  parameter int                    VERIFY      = 1,
  parameter int                    AUTO_START  = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs_n,
  output logic                  mem_we_n,
  output logic                  mem_oe_n,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_start,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam int CW = $clog2(IMAGE_WORDS + 1);
  localparam int WW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(IMAGE_WORDS - 1);
  localparam logic [WW-1:0] LAST_WE   = WW'(WE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_VREAD, S_VCMP, S_DONE, S_FAIL
  } state_t;

  state_t                r_state, w_nextState;
  logic [CW-1:0]         r_wordCnt, w_nextCnt;
  logic [WW-1:0]         r_weCnt, w_nextWeCnt;
  logic [DATA_WIDTH-1:0] r_data, w_nextData;
  logic                  r_autoPending;
  logic [ADDR_WIDTH-1:0] r_romAddr, w_romAddr, r_memAddr, w_memAddr, r_errAddr, w_errAddr;
  logic [DATA_WIDTH-1:0] r_memWdata, w_memWdata;
  logic                  r_romRd, w_romRd, r_csN, w_csN, r_weN, w_weN, r_oeN, w_oeN;
  logic                  r_busy, w_busy, r_done, w_done, r_cpuStart, w_cpuStart;
  logic                  r_error, w_error;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_wordCnt     <= '0;
      r_weCnt       <= '0;
      r_data        <= '0;
      r_autoPending <= (AUTO_START != 0);
      r_romAddr     <= '0;
      r_memAddr     <= '0;
      r_memWdata    <= '0;
      r_errAddr     <= '0;
      r_romRd       <= 1'b0;
      r_csN         <= 1'b1;
      r_weN         <= 1'b1;
      r_oeN         <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cpuStart    <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_wordCnt     <= w_nextCnt;
      r_weCnt       <= w_nextWeCnt;
      r_data        <= w_nextData;
      r_autoPending <= 1'b0;
      r_romAddr     <= w_romAddr;
      r_memAddr     <= w_memAddr;
      r_memWdata    <= w_memWdata;
      r_errAddr     <= w_errAddr;
      r_romRd       <= w_romRd;
      r_csN         <= w_csN;
      r_weN         <= w_weN;
      r_oeN         <= w_oeN;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_cpuStart    <= w_cpuStart;
      r_error       <= w_error;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_wordCnt;
    w_nextWeCnt = r_weCnt;
    w_nextData  = r_data;
    w_errAddr   = r_errAddr;
    case (r_state)
      S_IDLE:
        if (start || r_autoPending) begin
          w_nextState = S_FETCH;
          w_nextCnt   = '0;
        end
      S_FETCH: w_nextState = S_WAIT;
      S_WAIT: begin
        w_nextState = S_WRITE;
        w_nextData  = rom_data;
        w_nextWeCnt = '0;
      end
      S_WRITE:
        if (r_weCnt != LAST_WE) begin
          w_nextWeCnt = r_weCnt + 1'b1;
        end else if (r_wordCnt != LAST_WORD) begin
          w_nextCnt   = r_wordCnt + 1'b1;
          w_nextState = S_FETCH;
        end else if (VERIFY != 0) begin
          w_nextCnt   = '0;
          w_nextState = S_VREAD;
        end else begin
          w_nextState = S_DONE;
        end
      S_VREAD: w_nextState = S_VCMP;
      S_VCMP:
        if (rom_data != mem_rdata) begin
          w_nextState = S_FAIL;
          w_errAddr   = BASE_ADDR + ADDR_WIDTH'(r_wordCnt);
        end else if (r_wordCnt != LAST_WORD) begin
          w_nextCnt   = r_wordCnt + 1'b1;
          w_nextState = S_VREAD;
        end else begin
          w_nextState = S_DONE;
        end
      S_DONE, S_FAIL:
        if (start) begin
          w_nextState = S_FETCH;
          w_nextCnt   = '0;
          w_errAddr   = '0;
        end
      default: w_nextState = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    w_romRd    = 1'b0;
    w_romAddr  = r_romAddr;
    w_memAddr  = r_memAddr;
    w_memWdata = r_memWdata;
    w_csN      = 1'b1;
    w_weN      = 1'b1;
    w_oeN      = 1'b1;
    case (w_nextState)
      S_FETCH: begin
        w_romRd   = 1'b1;
        w_romAddr = ADDR_WIDTH'(w_nextCnt);
      end
      S_WRITE: begin
        w_csN      = 1'b0;
        w_weN      = 1'b0;
        w_memAddr  = BASE_ADDR + ADDR_WIDTH'(w_nextCnt);
        w_memWdata = w_nextData;
      end
      S_VREAD: begin
        w_romRd   = 1'b1;
        w_romAddr = ADDR_WIDTH'(w_nextCnt);
        w_csN     = 1'b0;
        w_oeN     = 1'b0;
        w_memAddr = BASE_ADDR + ADDR_WIDTH'(w_nextCnt);
      end
      S_VCMP: begin
        w_csN = 1'b0;
        w_oeN = 1'b0;
      end
      default: ;
    endcase
    w_busy     = (w_nextState == S_FETCH) || (w_nextState == S_WAIT) || (w_nextState == S_WRITE)
              || (w_nextState == S_VREAD) || (w_nextState == S_VCMP);
    w_done     = (w_nextState == S_DONE);
    w_cpuStart = (w_nextState == S_DONE) && (r_state != S_DONE);
    w_error    = (w_nextState == S_FAIL);
  end

  assign rom_addr  = r_romAddr;
  assign rom_rd    = r_romRd;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign mem_cs_n  = r_csN;
  assign mem_we_n  = r_weN;
  assign mem_oe_n  = r_oeN;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cpu_start = r_cpuStart;
  assign error     = r_error;
  assign err_addr  = r_errAddr;

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Parametrised successor to the original BIOS init block.
- After reset, or on a start request, it copies an IMAGE_WORDS-long program image from the boot ROM into main memory at BASE_ADDR.
- Optionally reads the copied image back and compares it against the ROM.
- Then hands control to the Control Unit with a one-cycle cpu_start pulse.
- Sits between the boot ROM, the main memory (active-low CS/WE/OE) and the Control Unit.

Parameters:
- ADDR_WIDTH, 32: memory and ROM address width.
- DATA_WIDTH, 32: word width.
- IMAGE_WORDS, 16: number of words copied. Must be ≥1. BASE_ADDR+IMAGE_WORDS-1 must fit in ADDR_WIDTH.
- BASE_ADDR, 0: destination address of word 0.
- WE_CYCLES, 1: number of cycles mem_we_n is held low per write. Must be ≥1.
- VERIFY, 1: 1 = read-back compare phase enabled.
- AUTO_START, 1: 1 = a load starts automatically in the first cycle after reset deassertion.

Ports:
- clock, input, 1: system clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- start, input, 1: request a (re)load. Sampled only in IDLE, DONE or FAIL.
- rom_addr, output, ADDR_WIDTH: boot ROM word index.
- rom_rd, output, 1: ROM read strobe. rom_data is valid in the next cycle and stable until the next rom_rd.
- rom_data, input, DATA_WIDTH: ROM read data.
- mem_addr, output, ADDR_WIDTH: memory address.
- mem_wdata, output, DATA_WIDTH: memory write data.
- mem_rdata, input, DATA_WIDTH: memory read data. Valid in the cycle after mem_cs_n=0 and mem_oe_n=0 are sampled.
- mem_cs_n, output, 1: memory chip select, active low.
- mem_we_n, output, 1: memory write enable, active low.
- mem_oe_n, output, 1: memory output enable, active low.
- busy, output, 1: load or verify in progress.
- done, output, 1: image loaded (and verified, if VERIFY=1). Level signal.
- cpu_start, output, 1: one-cycle pulse to the Control Unit.
- error, output, 1: verify mismatch. Level signal.
- err_addr, output, ADDR_WIDTH: memory address of the first mismatch.

Behaviour:
- Reset values (async on reset_n low, independent of clock):
  - state=IDLE; word counter=0.
  - mem_cs_n=mem_we_n=mem_oe_n=1.
  - rom_rd=0, busy=0, done=0, cpu_start=0, error=0.
  - rom_addr=0, mem_addr=0, mem_wdata=0, err_addr=0.
- All outputs are registered.
- Reset asserted mid-operation aborts immediately. Memory content is then undefined; there is no resume.
- States: IDLE, FETCH, WAIT, WRITE, VREAD, VCMP, DONE, FAIL.
- IDLE:
  - Goes to FETCH with counter i=0 if start=1, or on the first cycle after reset when AUTO_START=1.
  - busy=1 from FETCH onward.
- FETCH (1 cycle): rom_rd=1, rom_addr=i.
- WAIT (1 cycle): rom_rd=0. rom_data is latched into the data register at the end of this cycle.
- WRITE (WE_CYCLES cycles):
  - mem_cs_n=0, mem_we_n=0, mem_oe_n=1.
  - mem_addr=BASE_ADDR+i; mem_wdata=latched word.
  - Address and data are stable for all WE_CYCLES cycles.
  - On exit, strobes return high for at least the following FETCH cycle. There are no back-to-back write strobes across words.
  - If i<IMAGE_WORDS-1: i=i+1, go to FETCH.
  - Otherwise: go to VREAD with i=0 if VERIFY=1, else go to DONE.
- VREAD (1 cycle): rom_rd=1, rom_addr=i, mem_cs_n=0, mem_oe_n=0, mem_we_n=1, mem_addr=BASE_ADDR+i.
- VCMP (1 cycle):
  - mem_cs_n and mem_oe_n are held low; rom_rd=0.
  - rom_data is compared with mem_rdata across the full DATA_WIDTH.
  - Mismatch: error=1, err_addr=BASE_ADDR+i, go to FAIL.
  - Match and i<IMAGE_WORDS-1: i=i+1, go to VREAD.
  - Match and last word: go to DONE.
- DONE:
  - busy=0, done=1.
  - cpu_start=1 only in the first DONE cycle.
  - All strobes inactive.
- FAIL: busy=0, done=0, cpu_start is never asserted, error held.
- start in DONE or FAIL:
  - Clears done, error and err_addr.
  - Sets i=0 and goes to FETCH in the next cycle.
  - No cpu_start is issued until the next successful completion.
- start while busy is ignored and is not queued.
- Latency: with the start-sampling edge as edge 0, DONE (done=1, cpu_start=1) begins at edge IMAGE_WORDS*(2+WE_CYCLES) + VERIFY*2*IMAGE_WORDS.
- Counter width: clog2(IMAGE_WORDS+1) bits.
- Address arithmetic is ADDR_WIDTH-bit unsigned with no wrap checking, per the parameter constraint.

Test Plan:
- Single load, no verify:
  - Setup: IMAGE_WORDS=4, WE_CYCLES=1, VERIFY=0, AUTO_START=1, ROM word k = 32'h1000+k.
  - Required: memory[BASE_ADDR..BASE_ADDR+3] = 1000..1003.
  - Required: done rises 12 cycles after the first post-reset edge, with a single cpu_start pulse.
- Stretched writes with verify:
  - Setup: WE_CYCLES=3, VERIFY=1, IMAGE_WORDS=4.
  - Required: each mem_we_n low pulse lasts exactly 3 cycles with mem_addr/mem_wdata stable.
  - Required: done at edge 4*5+8=28; error=0.
- Verify failure:
  - Setup: the memory model corrupts the word at BASE_ADDR+2 (flips bit 0).
  - Required: error=1, err_addr=BASE_ADDR+2, FAIL entered after the third VCMP, done=0, cpu_start never asserted.
- Restart:
  - Stimulus: pulse start in FAIL (with corruption removed), then pulse start again in DONE.
  - Required: error and done clear in the next cycle.
  - Required: a full reload completes and a second cpu_start pulse is issued.
- Ignored start and AUTO_START=0:
  - Stimulus: start pulses during WRITE/VCMP have no effect and the load finishes on schedule.
  - Stimulus: with AUTO_START=0, the block stays in IDLE with strobes high until start=1.
- Reset mid-load:
  - Stimulus: drop reset_n asynchronously (between clock edges) during WRITE of word 1.
  - Required: mem_we_n and mem_cs_n go high immediately; busy=0 and done=0.
  - Required: after release with AUTO_START=1, the load restarts from word 0.
